// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// Produces quotient, remainder and a registered 5-digit BCD copy of the quotient.
module shift_sub_divider (
    input  logic        clkin,
    input  logic        clrn,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [7:0]  b,
    input  logic        load_a,
    input  logic        load_b,
    output logic [15:0] q,
    output logic [7:0]  r,
    output logic        done,
    output logic        div_zero,
    output logic        busy,
    output logic [19:0] q_bcd
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e      state, state_d;
    logic [15:0] a_reg, a_reg_d;
    logic [7:0]  b_reg, b_reg_d;
    logic [15:0] q_sh, q_sh_d;
    logic [7:0]  rem, rem_d;
    logic [3:0]  cnt, cnt_d;
    logic [15:0] q_d;
    logic [7:0]  r_d;
    logic        done_d, div_zero_d;

    logic [9:0]  trial;
    logic        fits;
    logic [7:0]  rem_next;
    logic [15:0] q_sh_next;

    // Double-dabble: shift in binary MSB first, add 3 to any digit >= 5 before each shift.
    function automatic logic [19:0] to_bcd(input logic [15:0] bin);
        logic [19:0] bcd;
        bcd = '0;
        for (int i = 15; i >= 0; i--) begin
            for (int d = 0; d < 5; d++) begin
                if (bcd[d*4 +: 4] >= 4'd5) begin
                    bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
                end
            end
            bcd = {bcd[18:0], bin[i]};
        end
        return bcd;
    endfunction

    // Extra top bit acts as the borrow flag of the trial subtraction.
    always_comb begin
        trial     = {1'b0, rem, q_sh[15]} - {2'b00, b_reg};
        fits      = ~trial[9];
        rem_next  = fits ? trial[7:0] : {rem[6:0], q_sh[15]};
        q_sh_next = {q_sh[14:0], fits};
    end

    always_comb begin
        state_d    = state;
        a_reg_d    = a_reg;
        b_reg_d    = b_reg;
        q_sh_d     = q_sh;
        rem_d      = rem;
        cnt_d      = cnt;
        q_d        = q;
        r_d        = r;
        done_d     = done;
        div_zero_d = div_zero;
        unique case (state)
            StIdle: begin
                if (load_a) a_reg_d = a;
                if (load_b) b_reg_d = b;
                if (start) begin
                    if (b_reg != 8'd0) begin
                        state_d    = StCalc;
                        q_sh_d     = a_reg;
                        rem_d      = 8'd0;
                        cnt_d      = 4'd0;
                        done_d     = 1'b0;
                        div_zero_d = 1'b0;
                    end else begin
                        state_d    = StDone;
                        q_d        = 16'hFFFF;
                        r_d        = 8'd0;
                        div_zero_d = 1'b1;
                        done_d     = 1'b1;
                    end
                end
            end
            StCalc: begin
                q_sh_d = q_sh_next;
                rem_d  = rem_next;
                cnt_d  = cnt + 4'd1;
                if (cnt == 4'd15) begin
                    q_d     = q_sh_next;
                    r_d     = rem_next;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!start) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state == StCalc);

    always_ff @(posedge clkin or negedge clrn) begin
        if (!clrn) begin
            state    <= StIdle;
            a_reg    <= '0;
            b_reg    <= '0;
            q_sh     <= '0;
            rem      <= '0;
            cnt      <= '0;
            q        <= '0;
            r        <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            q_bcd    <= '0;
        end else begin
            state    <= state_d;
            a_reg    <= a_reg_d;
            b_reg    <= b_reg_d;
            q_sh     <= q_sh_d;
            rem      <= rem_d;
            cnt      <= cnt_d;
            q        <= q_d;
            r        <= r_d;
            done     <= done_d;
            div_zero <= div_zero_d;
            q_bcd    <= to_bcd(q);
        end
    end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider: directed and random divisions against
// integer / and %, plus divide-by-zero, protocol and mid-run reset scenarios.
module tb_shift_sub_divider;

    logic        clkin = 1'b0;
    logic        clrn;
    logic        start;
    logic [15:0] a;
    logic [7:0]  b;
    logic        load_a;
    logic        load_b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        done;
    logic        div_zero;
    logic        busy;
    logic [19:0] q_bcd;

    int total  = 0;
    int passed = 0;

    shift_sub_divider dut (
        .clkin    (clkin),
        .clrn     (clrn),
        .start    (start),
        .a        (a),
        .b        (b),
        .load_a   (load_a),
        .load_b   (load_b),
        .q        (q),
        .r        (r),
        .done     (done),
        .div_zero (div_zero),
        .busy     (busy),
        .q_bcd    (q_bcd)
    );

    always #5 clkin = ~clkin;

    // Decimal digits of the quotient, packed one per nibble.
    function automatic logic [19:0] exp_bcd(input int v);
        logic [19:0] res;
        res = {4'((v / 10000) % 10), 4'((v / 1000) % 10), 4'((v / 100) % 10),
               4'((v / 10) % 10), 4'(v % 10)};
        return res;
    endfunction

    task automatic load_ops(input logic [15:0] av, input logic [7:0] bv);
        @(negedge clkin);
        a = av; b = bv; load_a = 1'b1; load_b = 1'b1;
        @(negedge clkin);
        load_a = 1'b0; load_b = 1'b0;
    endtask

    // Returns with the bench just after E0; counts cycles until done rises (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clkin);
            lat++;
        end
    endtask

    task automatic run_div(input logic [15:0] av, input logic [7:0] bv, output int lat);
        load_ops(av, bv);
        @(negedge clkin) start = 1'b1;
        @(negedge clkin) start = 1'b0;
        wait_done(lat);
    endtask

    task automatic test_reset;
        clrn = 1'b0; start = 1'b0; a = '0; b = '0; load_a = 1'b0; load_b = 1'b0;
        #1;
        total++;
        if ({q, r, done, div_zero, busy, q_bcd} !== '0)
            $display("FAIL reset_outputs: got q=%h r=%h done=%b dz=%b busy=%b bcd=%h, want all 0",
                     q, r, done, div_zero, busy, q_bcd);
        else passed++;
        @(negedge clkin) clrn = 1'b1;
    endtask

    task automatic test_directed;
        logic [15:0] av [6] = '{16'd1000, 16'd65535, 16'd65535, 16'd5, 16'd0, 16'd12345};
        logic [7:0]  bv [6] = '{8'd7,    8'd255,    8'd1,      8'd9,  8'd3,  8'd1};
        int lat, eq, er;
        for (int i = 0; i < 6; i++) begin
            run_div(av[i], bv[i], lat);
            eq = int'(av[i]) / int'(bv[i]);
            er = int'(av[i]) % int'(bv[i]);
            total++;
            if (lat !== 16) $display("FAIL dir_latency[%0d]: got %0d want 16", i, lat);
            else passed++;
            total++;
            if (q !== 16'(eq) || r !== 8'(er) || div_zero !== 1'b0 || busy !== 1'b0)
                $display("FAIL dir_result[%0d] %0d/%0d: got q=%0d r=%0d dz=%b busy=%b want q=%0d r=%0d dz=0 busy=0",
                         i, av[i], bv[i], q, r, div_zero, busy, eq, er);
            else passed++;
            @(negedge clkin);
            total++;
            if (q_bcd !== exp_bcd(eq))
                $display("FAIL dir_bcd[%0d]: got %h want %h", i, q_bcd, exp_bcd(eq));
            else passed++;
        end
    endtask

    task automatic test_random;
        logic [15:0] av;
        logic [7:0]  bv;
        int lat, eq, er;
        for (int i = 0; i < 40; i++) begin
            av = 16'($urandom);
            bv = 8'($urandom_range(255, 1));
            run_div(av, bv, lat);
            eq = int'(av) / int'(bv);
            er = int'(av) % int'(bv);
            total++;
            if (lat !== 16 || q !== 16'(eq) || r !== 8'(er))
                $display("FAIL rand[%0d] %0d/%0d: got lat=%0d q=%0d r=%0d want lat=16 q=%0d r=%0d",
                         i, av, bv, lat, q, r, eq, er);
            else passed++;
            @(negedge clkin);
            total++;
            if (q_bcd !== exp_bcd(eq))
                $display("FAIL rand_bcd[%0d]: got %h want %h", i, q_bcd, exp_bcd(eq));
            else passed++;
        end
    endtask

    task automatic test_div_zero;
        load_ops(16'd777, 8'd0);
        @(negedge clkin) start = 1'b1;
        @(negedge clkin) start = 1'b0;
        total++;
        if (q !== 16'hFFFF || r !== 8'd0 || div_zero !== 1'b1 || done !== 1'b1 || busy !== 1'b0)
            $display("FAIL div_zero: got q=%h r=%h dz=%b done=%b busy=%b want q=ffff r=0 dz=1 done=1 busy=0",
                     q, r, div_zero, done, busy);
        else passed++;
        @(negedge clkin);
        total++;
        if (q_bcd !== 20'h65535 || busy !== 1'b0)
            $display("FAIL div_zero_bcd: got bcd=%h busy=%b want bcd=65535 busy=0", q_bcd, busy);
        else passed++;
    endtask

    task automatic test_load_during_calc;
        int lat;
        load_ops(16'd1000, 8'd7);
        @(negedge clkin) start = 1'b1;
        @(negedge clkin) start = 1'b0;
        a = 16'd50; b = 8'd3; load_a = 1'b1; load_b = 1'b1;
        repeat (4) @(negedge clkin);
        load_a = 1'b0; load_b = 1'b0;
        wait_done(lat);
        total++;
        if (q !== 16'd142 || r !== 8'd6)
            $display("FAIL load_in_calc: got q=%0d r=%0d want q=142 r=6", q, r);
        else passed++;
        // A rerun without loading must still use 1000/7.
        @(negedge clkin) start = 1'b1;
        @(negedge clkin) start = 1'b0;
        wait_done(lat);
        total++;
        if (q !== 16'd142 || r !== 8'd6 || lat !== 16)
            $display("FAIL load_in_calc_rerun: got q=%0d r=%0d lat=%0d want q=142 r=6 lat=16", q, r, lat);
        else passed++;
    endtask

    task automatic test_hold_start;
        int lat, busy_seen;
        load_ops(16'd100, 8'd10);
        @(negedge clkin) start = 1'b1;
        @(negedge clkin);
        wait_done(lat);
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clkin);
            if (busy === 1'b1 || done !== 1'b1) busy_seen++;
        end
        total++;
        if (busy_seen !== 0 || q !== 16'd10 || r !== 8'd0)
            $display("FAIL hold_start: got restarts=%0d q=%0d r=%0d want restarts=0 q=10 r=0",
                     busy_seen, q, r);
        else passed++;
        start = 1'b0;
        @(negedge clkin);
        total++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL hold_start_idle: got done=%b busy=%b want done=1 busy=0", done, busy);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int lat;
        run_div(16'd200, 8'd9, lat);
        @(negedge clkin) start = 1'b1;
        @(negedge clkin) start = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b1)
            $display("FAIL b2b_restart: got done=%b busy=%b want done=0 busy=1", done, busy);
        else passed++;
        wait_done(lat);
        total++;
        if (q !== 16'd22 || r !== 8'd2 || lat !== 16)
            $display("FAIL b2b_result: got q=%0d r=%0d lat=%0d want q=22 r=2 lat=16", q, r, lat);
        else passed++;
    endtask

    task automatic test_reset_mid_calc;
        load_ops(16'd1000, 8'd7);
        @(negedge clkin) start = 1'b1;
        @(negedge clkin) start = 1'b0;
        repeat (8) @(negedge clkin);
        clrn = 1'b0;
        #1;
        total++;
        if ({q, r, done, busy, q_bcd, div_zero} !== '0)
            $display("FAIL reset_mid_calc: got q=%h r=%h done=%b busy=%b bcd=%h dz=%b want all 0",
                     q, r, done, busy, q_bcd, div_zero);
        else passed++;
        @(negedge clkin) clrn = 1'b1;
        // Operands were cleared, so an immediate start takes the divide-by-zero path.
        @(negedge clkin) start = 1'b1;
        @(negedge clkin) start = 1'b0;
        total++;
        if (div_zero !== 1'b1 || done !== 1'b1 || q !== 16'hFFFF || busy !== 1'b0)
            $display("FAIL reset_then_idle: got dz=%b done=%b q=%h busy=%b want dz=1 done=1 q=ffff busy=0",
                     div_zero, done, q, busy);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_div_zero;
        test_load_during_calc;
        test_hold_start;
        test_back_to_back;
        test_reset_mid_calc;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shift_sub_divider.md
# shift_sub_divider

Sequential restoring (shift-subtract) divider: the inverse of the team's shift-add multiplier. Divides a 16-bit unsigned dividend by an 8-bit unsigned divisor, one quotient bit per clock, and produces quotient, remainder and a 5-digit BCD copy of the quotient. It runs on the 10 kHz datapath clock and feeds the existing scan/7-segment display path through `q_bcd`.

## Interface
- Parameters: none. All widths are fixed.
- `clkin` in 1: datapath clock, rising edge.
- `clrn` in 1: reset, asynchronous, active-low.
- `start` in 1: run request, level-sensitive.
- `a` in 16: dividend.
- `b` in 8: divisor.
- `load_a` in 1: capture `a` into the dividend register.
- `load_b` in 1: capture `b` into the divisor register.
- `q` out 16: quotient.
- `r` out 8: remainder.
- `done` out 1: result valid.
- `div_zero` out 1: last run had divisor 0.
- `busy` out 1: high in CALC.
- `q_bcd` out 20: BCD of `q`, one nibble per digit, from ten-thousands `[19:16]` down to units `[3:0]`.

## Operation
- Reset: state IDLE. `a_reg`, `b_reg`, the working registers, `q`, `r`, `done`, `div_zero`, `busy` and `q_bcd` all clear to 0.
- IDLE:
  - `load_a` and `load_b` capture `a` and `b` independently and may both act on the same edge.
  - When `start` is 1 and `b_reg != 0`: go to CALC. Set `q_sh = a_reg`, `rem = 0`, `cnt = 0`, `done = 0`, `div_zero = 0`.
  - When `start` is 1 and `b_reg == 0`: go straight to DONE. Set `q = 16'hFFFF`, `r = 0`, `div_zero = 1`, `done = 1`.
- CALC, each edge:
  - Form the trial value: `t = {rem, q_sh[15]} - {1'b0, b_reg}`, 9 bits.
  - If `t` is non-negative: `rem = t[7:0]` and shift `1` into `q_sh[0]`.
  - Otherwise: `rem = {rem[6:0], q_sh[15]}` and shift `0` into `q_sh[0]`.
  - In both cases `q_sh` shifts left by one bit.
  - `cnt` increments each edge. On the edge where `cnt == 15`:
    - `q` takes the final shifted quotient.
    - `r` takes the final remainder.
    - `done` goes to 1 and state goes to DONE.
  - `load_a`, `load_b` and `start` are ignored in CALC.
- DONE:
  - Hold `q`, `r`, `done` and `div_zero`.
  - Stay in DONE while `start` is 1. Go to IDLE when `start` is 0.
  - `done` stays 1 in IDLE until the next run is accepted.
  - Loads are ignored in DONE.
- Width rules:
  - The partial remainder is always less than `b_reg`, which is at most 255, so the shifted value fits in 9 bits and `r` fits in 8 bits.
  - The quotient is at most 65535 and `q_bcd[19:16]` is at most 6.
- `q_bcd`: registered every edge from the current `q` (ten-thousands, thousands, hundreds, tens, units).

## Timing
- Let E0 be the edge where `start` is sampled high in IDLE. With a non-zero divisor, CALC runs on edges E1..E16.
- `q`, `r` and `done` are valid after E16, which gives a latency of 16 cycles from E0.
- `q_bcd` is valid one edge after `q` changes, i.e. after E17.
- Divide-by-zero: results are valid after E0, and `q_bcd` is valid after E1.
- `busy` is 1 from after E0 through E16 and is 0 after E16.
- Back-to-back runs need `start` low for at least one edge in DONE before IDLE can accept a new run.
- Holding `start` high never re-triggers a run.
- Asserting `clrn` mid-CALC aborts immediately with all outputs 0. After release the block is in IDLE, and the operands must be loaded again.

## Test plan
- Basic run: load a=1000, b=7, pulse start → after 16 cycles q=142, r=6, done=1, div_zero=0; one cycle later q_bcd=20'h00142.
- Maximum operands: a=65535, b=255 → q=257, r=0; a=65535, b=1 → q=65535, r=0, q_bcd=20'h65535.
- Dividend smaller than divisor: a=5, b=9 → q=0, r=5. Also a=0, b=3 → q=0, r=0.
- Divide by zero: b=0, start → one cycle later q=16'hFFFF, r=0, div_zero=1, done=1, and CALC is never entered (busy stays 0).
- Protocol:
  - Change a, b and pulse load_a/load_b during CALC → the result still matches the original operands.
  - Hold start high through DONE → no restart.
  - Drop start, then raise it again → a new run starts, done=0 during CALC.
- Reset: drop clrn at the 8th CALC cycle → q, r, done, busy and q_bcd go to 0 immediately; after release the state is IDLE.
